// File: rtl/qr_stream_pkg.sv
// Shared types and helpers for the QR core stream adapter.
package qr_stream_pkg;

  localparam int unsigned ROW_LANES  = 4;
  localparam int unsigned ROW_DATA_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FEED,
    ST_HOLD,
    ST_DRAIN
  } state_t;

  typedef logic signed [ROW_DATA_W-1:0] lane_t;
  typedef lane_t [ROW_LANES-1:0]        row_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/qr_row_fifo.sv
// First-word-fall-through row FIFO with synchronous clear; a push on a full
// FIFO is accepted only when a pop happens in the same cycle.
module qr_row_fifo
  import qr_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 52,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/qr_stream_adapter.sv
// Host-stream to QR core adapter: buffers one matrix, feeds rows on the core
// ready strobe, captures result rows and ends on core finish or timeout.
module qr_stream_adapter
  import qr_stream_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter int unsigned DATA_W    = 13,
  parameter int unsigned IN_DEPTH  = 9,
  parameter int unsigned OUT_DEPTH = 8,
  parameter bit          HOLD_LAST = 1'b1,
  parameter int unsigned TIMEOUT   = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  input  logic                    core_ready,
  output logic [LANES*DATA_W-1:0] core_data,
  output logic                    core_last_end,
  input  logic                    core_valid,
  input  logic [LANES*DATA_W-1:0] core_out,
  input  logic                    core_finish,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    done,
  output logic                    timeout,
  output logic                    overflow
);

  localparam int unsigned RW  = LANES * DATA_W;
  localparam int unsigned LCW = cnt_w(IN_DEPTH);
  localparam int unsigned TCW = cnt_w(TIMEOUT);

  state_t         state, state_nxt;
  logic [LCW-1:0] load_cnt;
  logic [TCW-1:0] tmo_cnt;

  logic           in_push, in_full, in_empty, in_row_last;
  logic [RW:0]    in_head;
  logic           out_push, out_pop, out_full, out_empty;
  logic [RW-1:0]  out_head;
  logic           run, issue, tmo_hit;

  assign run         = (state == ST_FEED) || (state == ST_HOLD);
  assign in_ready    = (state == ST_LOAD) && !in_full;
  assign in_push     = in_valid && in_ready;
  // The IN_DEPTH-th row always closes the matrix, whatever in_last says.
  assign in_row_last = in_last || (load_cnt == LCW'(IN_DEPTH - 1));
  assign issue       = (state == ST_FEED) && core_ready && !in_empty;
  assign tmo_hit     = run && (tmo_cnt == TCW'(TIMEOUT - 1));
  assign out_push    = run && core_valid;
  assign out_valid   = !out_empty;
  assign out_pop     = out_valid && out_ready;
  assign out_data    = out_empty ? '0 : out_head;

  qr_row_fifo #(
    .WIDTH (RW + 1),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (state == ST_IDLE),
    .push      (in_push),
    .push_data ({in_row_last, in_data}),
    .pop       (issue),
    .head_data (in_head),
    .full      (in_full),
    .empty     (in_empty)
  );

  qr_row_fifo #(
    .WIDTH (RW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (state == ST_IDLE),
    .push      (out_push),
    .push_data (core_out),
    .pop       (out_pop),
    .head_data (out_head),
    .full      (out_full),
    .empty     (out_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_LOAD;
      ST_LOAD:  if (in_push && in_row_last) state_nxt = ST_FEED;
      ST_FEED,
      ST_HOLD: begin
        if (core_finish || tmo_hit)       state_nxt = ST_DRAIN;
        else if (issue && in_head[RW])    state_nxt = ST_HOLD;
      end
      ST_DRAIN: if (out_empty) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      load_cnt      <= '0;
      tmo_cnt       <= '0;
      core_data     <= '0;
      core_last_end <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= run && core_finish;

      if (state == ST_IDLE) begin
        load_cnt <= '0;
        tmo_cnt  <= '0;
        timeout  <= 1'b0;
        overflow <= 1'b0;
      end
      if (in_push) load_cnt <= load_cnt + LCW'(1);
      if (run)     tmo_cnt  <= tmo_cnt + TCW'(1);
      if (tmo_hit && !core_finish) timeout <= 1'b1;
      if (out_push && out_full && !out_pop) overflow <= 1'b1;

      // Issued row stays registered only while holding with HOLD_LAST set.
      if (issue) begin
        core_data     <= in_head[RW-1:0];
        core_last_end <= in_head[RW];
      end else if (!(state == ST_HOLD && HOLD_LAST)) begin
        core_data     <= '0;
        core_last_end <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qr_stream_adapter.sv
// Directed self-checking bench for qr_stream_adapter with default parameters.
module tb_qr_stream_adapter;
  import qr_stream_pkg::*;

  localparam int unsigned LANES   = 4;
  localparam int unsigned DATA_W  = 13;
  localparam int unsigned W       = LANES * DATA_W;
  localparam int unsigned TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_last, core_ready, core_valid, core_finish, out_ready;
  logic [W-1:0] in_data, core_out;
  logic         in_ready, core_last_end, out_valid, done, timeout, overflow;
  logic [W-1:0] core_data, out_data;

  always #5 clk = ~clk;

  qr_stream_adapter #(
    .LANES     (LANES),
    .DATA_W    (DATA_W),
    .IN_DEPTH  (9),
    .OUT_DEPTH (8),
    .HOLD_LAST (1'b1),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .core_ready    (core_ready),
    .core_data     (core_data),
    .core_last_end (core_last_end),
    .core_valid    (core_valid),
    .core_out      (core_out),
    .core_finish   (core_finish),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .done          (done),
    .timeout       (timeout),
    .overflow      (overflow)
  );

  typedef struct {
    logic         core_ready;
    logic [W-1:0] exp_data;
    logic         exp_last;
  } feed_vec_t;

  feed_vec_t    fv [17];
  logic [W-1:0] rows [10];
  int           n_vec = 0;
  int           n_err = 0;

  function automatic logic [W-1:0] mk_row(input int l0, input int l1, input int l2, input int l3);
    logic [DATA_W-1:0] a, b, c, d;
    a = l0[DATA_W-1:0];
    b = l1[DATA_W-1:0];
    c = l2[DATA_W-1:0];
    d = l3[DATA_W-1:0];
    return {d, c, b, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " in_ready"},      64'(in_ready),      64'd0);
    check({tag, " core_data"},     64'(core_data),     64'd0);
    check({tag, " core_last_end"}, 64'(core_last_end), 64'd0);
    check({tag, " out_valid"},     64'(out_valid),     64'd0);
    check({tag, " out_data"},      64'(out_data),      64'd0);
    check({tag, " done"},          64'(done),          64'd0);
    check({tag, " timeout"},       64'(timeout),       64'd0);
    check({tag, " overflow"},      64'(overflow),      64'd0);
  endtask

  task automatic wait_load(input string name);
    int k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    check(name, 64'(in_ready), 64'd1);
  endtask

  task automatic load_rows(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = rows[first + i];
      in_last  = (i == n - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic apply_feed(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      core_ready = fv[i].core_ready;
      step();
      check($sformatf("feed%0d data", i), 64'(core_data),     64'(fv[i].exp_data));
      check($sformatf("feed%0d last", i), 64'(core_last_end), 64'(fv[i].exp_last));
    end
    core_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int done_seen;

    for (int i = 0; i < 10; i++)
      rows[i] = mk_row(i * 10 + 1, -(i * 10 + 2), 4095 - i, -4096 + i);

    // 9-row matrix, ready every cycle, then HOLD with ready ignored
    for (int i = 0; i < 9; i++)
      fv[i] = '{1'b1, rows[i], (i == 8)};
    fv[9]  = '{1'b1, rows[8], 1'b1};
    fv[10] = '{1'b0, rows[8], 1'b1};
    // 3-row matrix with ready pulsed every other cycle
    fv[11] = '{1'b1, rows[3], 1'b0};
    fv[12] = '{1'b0, '0,      1'b0};
    fv[13] = '{1'b1, rows[4], 1'b0};
    fv[14] = '{1'b0, '0,      1'b0};
    fv[15] = '{1'b1, rows[5], 1'b1};
    fv[16] = '{1'b1, rows[5], 1'b1};

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    core_ready = 1'b0; core_valid = 1'b0; core_out = '0; core_finish = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check_reset("reset");
    reset = 1'b0;

    // Run 1: full-depth matrix
    wait_load("run1 load ready");
    load_rows(0, 9);
    check("run1 in_ready after load", 64'(in_ready), 64'd0);
    apply_feed(0, 10);
    core_finish = 1'b1;
    step();
    core_finish = 1'b0;
    check("run1 done pulse", 64'(done), 64'd1);
    step();
    check("run1 done low", 64'(done), 64'd0);
    check("run1 drain zero data", 64'(core_data), 64'd0);

    // Run 2: gapped feed, then capture with host always ready
    wait_load("run2 load ready");
    load_rows(3, 3);
    apply_feed(11, 16);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      core_valid = 1'b1;
      core_out   = rows[k];
      step();
      check($sformatf("cap%0d valid", k), 64'(out_valid), 64'd1);
      check($sformatf("cap%0d data", k),  64'(out_data),  64'(rows[k]));
    end
    core_valid  = 1'b0;
    core_finish = 1'b1;
    step();
    core_finish = 1'b0;
    check("run2 done pulse", 64'(done), 64'd1);
    check("run2 out drained", 64'(out_valid), 64'd0);
    check("run2 no overflow", 64'(overflow), 64'd0);
    step();
    check("run2 done low", 64'(done), 64'd0);
    out_ready = 1'b0;

    // Run 3: 10 results with host stalled -> two dropped
    wait_load("run3 load ready");
    load_rows(9, 1);
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    check("run3 single row", 64'(core_data), 64'(rows[9]));
    check("run3 single last", 64'(core_last_end), 64'd1);
    for (int k = 0; k < 10; k++) begin
      core_valid = 1'b1;
      core_out   = rows[k];
      step();
      check($sformatf("ovf after push%0d", k), 64'(overflow), 64'(k >= 8));
    end
    core_valid  = 1'b0;
    core_finish = 1'b1;
    step();
    core_finish = 1'b0;
    check("run3 done pulse", 64'(done), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d valid", k), 64'(out_valid), 64'd1);
      check($sformatf("drain%0d data", k),  64'(out_data),  64'(rows[k]));
      step();
    end
    check("run3 rows 9-10 lost", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Run 4: core never finishes
    wait_load("run4 load ready");
    load_rows(0, 1);
    done_seen = 0;
    for (int k = 1; k < int'(TIMEOUT); k++) begin
      step();
      if (done) done_seen++;
      if (k == 50) check("run4 idle feed zero", 64'(core_data), 64'd0);
    end
    check("timeout before limit", 64'(timeout), 64'd0);
    step();
    if (done) done_seen++;
    check("timeout at limit", 64'(timeout), 64'd1);
    check("no done on timeout", 64'(done_seen), 64'd0);

    // Run 5: reset in the middle of FEED discards the buffered rows
    wait_load("run5 load ready");
    load_rows(0, 2);
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    check("run5 first row", 64'(core_data), 64'(rows[0]));
    reset = 1'b1;
    step();
    check_reset("midreset");
    reset = 1'b0;
    wait_load("run5 reload ready");
    load_rows(7, 1);
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
    check("run5 fresh row", 64'(core_data), 64'(rows[7]));
    check("run5 fresh last", 64'(core_last_end), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
